// File: rtl/haraka_pkg.sv
// -----------------------------------------------------------------------------
// haraka_pkg
// Shared definitions for the Haraka-S AES round engine:
//   - aes_state_t : one 128-bit AES state, byte 0 in bits [127:120],
//                   column-major (byte index = row + 4*column)
//   - state_t     : engine FSM encoding, also exported on the debug port
//   - xtime       : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   - sbox        : AES S-box lookup from a constant table
// -----------------------------------------------------------------------------
package haraka_pkg;

   typedef logic [127:0] aes_state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Rows of 16 entries, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Entry b starts at bit 2047-8*b = 8*(255-b)+7, i.e. {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b111} -: 8];
   endfunction

endpackage

// File: rtl/haraka_aes_rounds_if.sv
// -----------------------------------------------------------------------------
// haraka_aes_rounds_if
// Bundles the engine's input handshake, round-constant fetch and output
// handshake.
//   in_valid/in_ready/in_data    : block input (LANES x 128 bits)
//   rc_sel/rc_in                 : round-constant index out, constants back in
//                                  combinationally in the same cycle
//   out_valid/out_ready/out_data : finished block output
// modport slave  : the engine
// modport master : the surrounding datapath (producer, constant store, consumer)
// -----------------------------------------------------------------------------
interface haraka_aes_rounds_if #(
   parameter int LANES  = 4,
   parameter int ROUNDS = 2,
   parameter int RCW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*128-1:0]   in_data;
   logic [RCW-1:0]         rc_sel;
   logic [LANES*128-1:0]   rc_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*128-1:0]   out_data;

   modport slave (
      input  in_valid, in_data, rc_in, out_ready,
      output in_ready, rc_sel, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, rc_in, out_ready,
      input  in_ready, rc_sel, out_valid, out_data
   );
endinterface

// File: rtl/aes_round_comb.sv
// -----------------------------------------------------------------------------
// aes_round_comb
// Purely combinational single-lane AES round:
//   o_state = AddRC(MixColumns?(ShiftRows(SubBytes(i_state))), i_rc)
// Ports:
//   i_state  : input state
//   i_rc     : round constant for this lane
//   i_mix_en : 1 applies MixColumns, 0 bypasses it (FIPS-197 final round)
//   o_state  : round result
// -----------------------------------------------------------------------------
module aes_round_comb
   import haraka_pkg::*;
(
   input  aes_state_t i_state,
   input  aes_state_t i_rc,
   input  logic       i_mix_en,
   output aes_state_t o_state
);

   // Byte view: element 0 is the most significant byte of the state.
   logic [0:15][7:0] w_in;
   logic [0:15][7:0] w_rc;
   logic [0:15][7:0] w_sb;
   logic [0:15][7:0] w_sr;
   logic [0:15][7:0] w_mc;

   assign w_in = i_state;
   assign w_rc = i_rc;

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   always_comb begin
      w_sb = '0;
      w_sr = '0;
      w_mc = '0;
      for (int i = 0; i < 16; i++) begin
         w_sb[i] = sbox(w_in[i]);
      end
      // Row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         if (i_mix_en) begin
            {w_mc[4*c], w_mc[4*c+1], w_mc[4*c+2], w_mc[4*c+3]} =
               mix_col({w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]});
         end else begin
            {w_mc[4*c], w_mc[4*c+1], w_mc[4*c+2], w_mc[4*c+3]} =
               {w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]};
         end
      end
   end

   assign o_state = w_mc ^ w_rc;

endmodule

// File: rtl/haraka_aes_rounds.sv
// -----------------------------------------------------------------------------
// haraka_aes_rounds
// Iterative multi-lane AES round engine: applies ROUNDS AES rounds, one per
// clock, to LANES independent 128-bit states using one round stage per lane.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_data, rc_sel/rc_in, out_valid/
//                  out_ready/out_data
//   o_dbg_state  : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and data stable until that edge, and ready
// never depends on valid. The only combinational input-to-output path is
// out_ready -> in_ready (in DONE), which lets a new block load on the same edge
// the finished one is taken.
// -----------------------------------------------------------------------------
module haraka_aes_rounds
   import haraka_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int ROUNDS   = 2,
   parameter int MIX_LAST = 1,
   parameter int RCW      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   haraka_aes_rounds_if.slave  bus,
   output state_t              o_dbg_state
);

   state_t               r_state;
   state_t               w_next_state;
   logic [RCW-1:0]       r_cnt;
   logic [LANES*128-1:0] r_data;
   logic [LANES*128-1:0] w_round;
   logic                 w_in_ready;
   logic                 w_out_valid;
   logic [RCW-1:0]       w_rc_sel;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_mix_en;

   assign w_last   = (r_cnt == RCW'(ROUNDS - 1));
   assign w_accept = bus.in_valid && w_in_ready;
   // Only the final round may drop MixColumns.
   assign w_mix_en = (MIX_LAST != 0) || !w_last;

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_rc_sel     = '0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next_state = ST_BUSY;
         end
         ST_BUSY: begin
            w_rc_sel = r_cnt;
            if (w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = bus.out_ready;
            if (bus.out_ready) w_next_state = bus.in_valid ? ST_BUSY : ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_data <= bus.in_data;
      end else if (r_state == ST_BUSY) begin
         r_cnt  <= w_last ? '0 : r_cnt + RCW'(1);
         r_data <= w_round;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_round_comb u_round (
         .i_state  (r_data[128*g +: 128]),
         .i_rc     (bus.rc_in[128*g +: 128]),
         .i_mix_en (w_mix_en),
         .o_state  (w_round[128*g +: 128])
      );
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.rc_sel    = w_rc_sel;
   assign bus.out_data  = r_data;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_haraka_aes_rounds.sv
// -----------------------------------------------------------------------------
// tb_haraka_aes_rounds
// Two engines: dut_a (2 lanes, 4 rounds, FIPS final round without MixColumns)
// and dut_b (2 lanes, 1 round, Haraka final round with MixColumns). The
// reference model builds its S-box from the GF(2^8) inverse and affine map.
// -----------------------------------------------------------------------------
module tb_haraka_aes_rounds;

   localparam int RA   = 4;
   localparam int RB   = 1;
   localparam int NBLK = 1000;

   logic clk = 1'b0;
   logic rst_a_n = 1'b0;
   logic rst_b_n = 1'b0;
   always #5 clk = ~clk;

   haraka_aes_rounds_if #(.LANES(2), .ROUNDS(RA)) bus_a ();
   haraka_aes_rounds_if #(.LANES(2), .ROUNDS(RB)) bus_b ();
   haraka_pkg::state_t dbg_a;
   haraka_pkg::state_t dbg_b;

   haraka_aes_rounds #(.LANES(2), .ROUNDS(RA), .MIX_LAST(0)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .bus(bus_a), .o_dbg_state(dbg_a));
   haraka_aes_rounds #(.LANES(2), .ROUNDS(RB), .MIX_LAST(1)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .bus(bus_b), .o_dbg_state(dbg_b));

   // External constant stores, answering combinationally.
   logic [255:0] rc_tab_a [4];
   logic [255:0] rc_tab_b [2];
   assign bus_a.rc_in = rc_tab_a[bus_a.rc_sel];
   assign bus_b.rc_in = rc_tab_b[bus_b.rc_sel];

   // ---------------- scoreboard state ----------------
   logic [255:0] exp_q_a[$];
   logic [255:0] exp_q_b[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_out_a  = 0;
   int n_out_b  = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sb_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] v, inv;
      for (int x = 0; x < 256; x++) begin
         v = 8'(x);
         inv = 8'h01;
         for (int e = 0; e < 254; e++) inv = gmul(inv, v);
         sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                              input bit mix);
      logic [7:0] m [4][4];
      logic [7:0] t [4][4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[r][c] = sb_tab[s[127-8*(r+4*c) -: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r][c] = m[r][(c+r)%4];
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            m[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
            m[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
            m[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
            m[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
         end
      end else begin
         m = t;
      end
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = m[r][c] ^ k[127-8*(r+4*c) -: 8];
      return o;
   endfunction

   function automatic logic [255:0] ref_block(input logic [255:0] din, input bit is_b);
      logic [255:0] o, rk;
      logic [127:0] s;
      int nr;
      o = '0;
      nr = is_b ? RB : RA;
      for (int l = 0; l < 2; l++) begin
         s = din[128*l +: 128];
         for (int r = 0; r < nr; r++) begin
            rk = is_b ? rc_tab_b[r] : rc_tab_a[r];
            s = ref_round(s, rk[128*l +: 128], is_b ? 1'b1 : (r != nr - 1));
         end
         o[128*l +: 128] = s;
      end
      return o;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // ---------------- monitors (sample on the falling edge) ----------------
   always @(negedge clk) begin
      if (rst_a_n) begin
         if (bus_a.out_valid && bus_a.out_ready) begin
            n_out_a++;
            chk("a_sb_pending", 256'(exp_q_a.size() != 0), 256'(1));
            if (exp_q_a.size() != 0) chk("a_sb_data", bus_a.out_data, exp_q_a.pop_front());
         end
         if (bus_a.in_valid && bus_a.in_ready) exp_q_a.push_back(ref_block(bus_a.in_data, 1'b0));
      end
   end

   always @(negedge clk) begin
      if (rst_b_n) begin
         if (bus_b.out_valid && bus_b.out_ready) begin
            n_out_b++;
            chk("b_sb_pending", 256'(exp_q_b.size() != 0), 256'(1));
            if (exp_q_b.size() != 0) chk("b_sb_data", bus_b.out_data, exp_q_b.pop_front());
         end
         if (bus_b.in_valid && bus_b.in_ready) exp_q_b.push_back(ref_block(bus_b.in_data, 1'b1));
      end
   end

   // ---------------- directed sequence ----------------
   logic [127:0] fips_in, fips_rk, fips_out;
   logic [255:0] tmp, blk_x, blk_y, exp_x;
   int base, sent, cyc;
   bit acc;

   initial begin
      fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      fips_rk  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_out = 128'ha49c7ff2689f352b6b5bea43026a5049;
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
      build_sbox();
      for (int r = 0; r < 4; r++) rc_tab_a[r] = rand256();
      rc_tab_b[0] = '0;
      rc_tab_b[1] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1; rst_a_n = 1'b1; rst_b_n = 1'b1;
      @(negedge clk);
      chk("a_rst_in_ready",  256'(bus_a.in_ready), 256'(1));
      chk("a_rst_out_valid", 256'(bus_a.out_valid), 256'(0));
      chk("a_rst_out_data",  bus_a.out_data, 256'(0));
      chk("a_rst_rc_sel",    256'(bus_a.rc_sel), 256'(0));
      chk("b_rst_in_ready",  256'(bus_b.in_ready), 256'(1));
      chk("b_rst_out_valid", 256'(bus_b.out_valid), 256'(0));
      chk("b_rst_state",     256'(dbg_b), 256'(haraka_pkg::ST_IDLE));

      // Zero block through one Haraka round: every byte becomes 0x63
      @(posedge clk); #1;
      bus_b.out_ready = 1'b1; bus_b.in_data = '0; bus_b.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
      chk("b_zero_busy_valid", 256'(bus_b.out_valid), 256'(0));
      chk("b_zero_busy_state", 256'(dbg_b), 256'(haraka_pkg::ST_BUSY));
      @(posedge clk); #1;
      chk("b_zero_lat_valid", 256'(bus_b.out_valid), 256'(1));
      chk("b_zero_data", bus_b.out_data, {32{8'h63}});
      @(posedge clk); #1;
      chk("b_zero_idle_valid", 256'(bus_b.out_valid), 256'(0));
      chk("b_zero_idle_ready", 256'(bus_b.in_ready), 256'(1));

      // FIPS-197 App. B round 1 on lane 0, random lane 1
      tmp = rand256();
      rc_tab_b[0] = {tmp[255:128], fips_rk};
      rc_tab_b[1] = rc_tab_b[0];
      tmp = rand256();
      bus_b.in_data = {tmp[127:0], fips_in}; bus_b.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b_fips_valid", 256'(bus_b.out_valid), 256'(1));
      chk("b_fips_lane0", 256'(bus_b.out_data[127:0]), 256'(fips_out));
      @(posedge clk); #1;

      // ROUNDS=4, MIX_LAST=0: rc_sel walks 0..3
      bus_a.out_ready = 1'b1; bus_a.in_data = rand256(); bus_a.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      for (int i = 0; i < RA; i++) begin
         chk("a_rc_sel_seq", 256'(bus_a.rc_sel), 256'(i));
         @(posedge clk); #1;
      end
      chk("a_lat_valid", 256'(bus_a.out_valid), 256'(1));
      chk("a_done_rc_sel", 256'(bus_a.rc_sel), 256'(0));
      @(posedge clk); #1;

      // Backpressure: hold out_ready low for 5 DONE cycles, then hand off
      blk_x = rand256(); blk_y = rand256(); exp_x = ref_block(blk_x, 1'b0);
      bus_a.out_ready = 1'b0; bus_a.in_data = blk_x; bus_a.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.in_data = blk_y;
      repeat (RA) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("a_bp_valid", 256'(bus_a.out_valid), 256'(1));
         chk("a_bp_in_ready", 256'(bus_a.in_ready), 256'(0));
         chk("a_bp_data", bus_a.out_data, exp_x);
         @(posedge clk); #1;
      end
      bus_a.out_ready = 1'b1;
      #1;
      chk("a_bp_pass_ready", 256'(bus_a.in_ready), 256'(1));
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      chk("a_bp_drop_valid", 256'(bus_a.out_valid), 256'(0));
      chk("a_bp_reload_state", 256'(dbg_a), 256'(haraka_pkg::ST_BUSY));
      repeat (RA + 1) @(posedge clk);
      #1;

      // Reset mid-BUSY at cnt=1
      bus_a.in_data = rand256(); bus_a.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("a_mid_rc_sel", 256'(bus_a.rc_sel), 256'(1));
      rst_a_n = 1'b0;
      exp_q_a.delete();
      #1;
      chk("a_arst_valid", 256'(bus_a.out_valid), 256'(0));
      chk("a_arst_in_ready", 256'(bus_a.in_ready), 256'(1));
      chk("a_arst_state", 256'(dbg_a), 256'(haraka_pkg::ST_IDLE));
      chk("a_arst_data", bus_a.out_data, 256'(0));
      @(posedge clk); #1;
      rst_a_n = 1'b1;
      base = n_out_a;
      bus_a.in_data = rand256(); bus_a.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      repeat (RA + 2) @(posedge clk);
      #1;
      chk("a_post_rst_count", 256'(n_out_a - base), 256'(1));

      // Random stream with random in_valid / out_ready
      base = n_out_a; sent = 0; cyc = 0;
      while (sent < NBLK && cyc < 40000) begin
         if (!bus_a.in_valid && ($urandom_range(0, 1) == 1)) begin
            bus_a.in_data = rand256(); bus_a.in_valid = 1'b1;
         end
         bus_a.out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         acc = bus_a.in_valid && bus_a.in_ready;
         if (acc) sent++;
         @(posedge clk); #1;
         cyc++;
         if (acc) bus_a.in_valid = 1'b0;
      end
      bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q_a.size() != 0; i++) @(posedge clk);
      #1;
      chk("a_stream_sent", 256'(sent), 256'(NBLK));
      chk("a_stream_count", 256'(n_out_a - base), 256'(NBLK));
      chk("a_q_empty", 256'(exp_q_a.size()), 256'(0));
      chk("b_q_empty", 256'(exp_q_b.size()), 256'(0));
      chk("b_out_count", 256'(n_out_b), 256'(2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/haraka_aes_rounds.md
# haraka_aes_rounds

Parametrised, iterative multi-lane AES round engine for the Haraka-S datapath. It applies ROUNDS consecutive AES rounds to LANES independent 128-bit states, one round per clock, reusing a single registered round stage per lane. It fetches round constants from an external constant store via a round-select index and has valid/ready handshakes on both sides. It replaces single-round, free-running AES instances in the permutation pipeline.

## Interface
- LANES, default 4: number of parallel 128-bit AES states. Legal range is 1..8.
- ROUNDS, default 2: AES rounds applied per accepted block. Legal range is 1..16.
- MIX_LAST, default 1: controls MixColumns on the final round. 1 means MixColumns is applied on the final round (Haraka). 0 means it is skipped (FIPS-197 final round).
- RCW, derived, equal to max(1, $clog2(ROUNDS)): width of the round-select index.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  engine can accept a block this cycle.
- in_data  input  LANES*128  lane i occupies bits [128*i+127 : 128*i]. State byte 0 is in bits [127:120] of each lane, column-major.
- rc_sel  output  RCW  index of the round constant needed this cycle.
- rc_in  input  LANES*128  round constants for round rc_sel, one per lane with the same packing. The external store returns them combinationally in the same cycle.
- out_valid  output  1  out_data holds a finished block.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  LANES*128  result of ROUNDS rounds.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: rounds in progress.
  - DONE: out_valid=1.
- Accept happens when in_valid && in_ready is high on a clock edge. On accept:
  - state_q <= in_data
  - cnt <= 0
  - FSM goes to BUSY.
- BUSY, each cycle:
  - rc_sel = cnt.
  - For every lane, state_q <= AddRC(MixColumns(ShiftRows(SubBytes(state_q))), rc_in lane).
  - When cnt == ROUNDS-1 and MIX_LAST=0, MixColumns is bypassed.
  - If cnt == ROUNDS-1, the FSM goes to DONE. Otherwise cnt <= cnt+1.
- DONE:
  - out_data = state_q.
  - out_valid stays high and out_data stays stable until out_ready is sampled high.
  - On out_valid && out_ready with in_valid low, the FSM goes to IDLE.
- Back-to-back operation: in DONE, in_ready = out_ready. When the output handshake and an input accept happen together, the new block loads and the FSM goes directly to BUSY.
- in_data outside an accept and rc_in outside BUSY are ignored.
- Outside BUSY, rc_sel is held at 0.
- out_data is driven from state_q at all times; it is meaningful only while out_valid is high.
- in_valid high while the engine is BUSY is not accepted (in_ready=0). Upstream must hold its data until in_ready is asserted.
- Reset can arrive at any time, including mid-BUSY or mid-DONE. It immediately forces:
  - FSM to IDLE
  - cnt=0
  - state_q=0
  - out_valid=0
  - in_ready=1 while reset is deasserted high after reset is released.
  - The in-flight block is discarded, with no partial output.

## Timing
- Reset values:
  - in_ready=1 (once reset is released)
  - out_valid=0
  - out_data=0
  - rc_sel=0
- Latency: a block accepted at edge k gives out_valid=1 in the cycle after edge k+ROUNDS.
- Throughput: one block per ROUNDS+1 cycles when out_ready is held high. With ROUNDS=1, in_ready and out_valid alternate on successive cycles.
- The rc_sel → rc_in path is combinational within one cycle and is included in the round-stage critical path.
- No combinational path exists from in_valid to out_valid, or from out_ready to out_valid. The only combinational input-to-output path is out_ready → in_ready.

## Structure
- Shared package haraka_pkg holds:
  - typedef aes_state_t = logic [127:0].
  - GF(2^8) xtime function.
  - AES S-box constant table.
- One sub-module, aes_round_comb: a purely combinational single-lane AES round (SubBytes, ShiftRows, MixColumns bypassable via a mix_en input, AddRC).
  - It is instantiated LANES times in a generate loop.
  - It reuses the existing S_box, ShiftRows, MixColumns and AddRC blocks; their pipeline register is not included.
- The top level holds only the FSM, cnt, state_q and the handshake logic.

## Test plan
- Zero block, LANES=4, ROUNDS=1, rc_in=0, out_ready=1: every lane of out_data is 0x63 repeated 16 times, and out_valid is asserted 2 cycles after accept.
- FIPS-197 App. B round 1, with LANES=1, ROUNDS=1, MIX_LAST=1:
  - in_data = 193de3bea0f4e22b9ac68d2ae9f84808
  - rc_in = a0fafe1788542cb123a339392a6c7605
  - out_data must equal a49c7ff2689f352b6b5bea43026a5049.
- ROUNDS=2, MIX_LAST=0, with a different per-lane rc for each rc_sel: rc_sel sequence is 0 then 1, and each lane's out_data matches the reference model (round 2 without MixColumns).
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_valid and out_data stay stable and in_ready=0. Then raise out_ready together with in_valid: the next block is accepted on the same edge and out_valid drops.
- Reset asserted mid-BUSY (cnt=1, ROUNDS=4): out_valid=0 and in_ready=1 immediately. After release, a new block completes with the correct result and no output from the aborted block.
- Random stream of 1000 blocks, with in_valid and out_ready each randomly high 50% of the time: the output sequence equals the reference model in order, with no drops or duplicates.
